// File: rtl/rush3d_avalon_pkg.sv
// Shared widths, FSM states and helpers for the Avalon-MM burst responder.
package rush3d_avalon_pkg;

    localparam int DATA_W  = 64;
    localparam int BE_W    = DATA_W / 8;
    localparam int ADDR_W  = 29;
    localparam int BCNT_W  = 8;
    localparam int DRAIN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITE_BURST = 2'd1,
        ST_READ_ISSUE  = 2'd2,
        ST_READ_DRAIN  = 2'd3
    } state_e;

    // A zero burstcount is serviced as a single beat.
    function automatic logic [BCNT_W-1:0] eff_count(input logic [BCNT_W-1:0] bc);
        return (bc == '0) ? BCNT_W'(1) : bc;
    endfunction

endpackage

// File: rtl/responder_ram.sv
// Simple dual-port synchronous RAM: byte-enabled write, registered read,
// a same-edge write to the read address is forwarded into the read word.
module responder_ram
    import rush3d_avalon_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [BE_W-1:0]      wbe,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_BITS];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Next read word, with write-first forwarding of enabled bytes
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
            for (int b = 0; b < BE_W; b++) begin
                if (we && (waddr == raddr) && wbe[b]) begin
                    rdata_d[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    // Byte-enabled storage update; contents survive reset by design
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wbe[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port (one cycle of the total read latency)
    always_ff @(posedge clock) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/avalon_burst_responder.sv
// Avalon-MM burst slave backed by a local RAM. Reads are issued one beat per
// cycle; RAM latency plus a valid/data shift pipeline gives READ_LATENCY.
module avalon_burst_responder
    import rush3d_avalon_pkg::*;
#(
    parameter int DEPTH_LOG2   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [BCNT_W-1:0] burstcount,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic [BE_W-1:0]   byteenable,
    input  logic              stall,
    output logic              waitrequest,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              busy,
    output logic              protocol_error
);

    localparam int NSTG = READ_LATENCY - 1;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] base_q, base_d;
    logic [BCNT_W-1:0]     count_q, count_d;
    logic [BCNT_W-1:0]     beat_q, beat_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  perr_q, perr_d;
    logic                  busy_q, busy_d;

    logic [BCNT_W-1:0]     bc_eff;
    logic [DEPTH_LOG2-1:0] beat_idx;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic                  ram_we, ram_re;
    logic                  accept_wr, accept_rd;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  ram_vld_q, ram_vld_d;

    logic                  pipe_vld_q [NSTG];
    logic                  pipe_vld_d [NSTG];
    logic [DATA_W-1:0]     pipe_dat_q [NSTG];
    logic [DATA_W-1:0]     pipe_dat_d [NSTG];

    logic                  unused_addr_bits;

    assign unused_addr_bits = ^address[ADDR_W-1:DEPTH_LOG2];

    assign waitrequest = reset | stall | (state_q == ST_READ_ISSUE) | (state_q == ST_READ_DRAIN);
    assign accept_wr   = write & ~waitrequest;
    assign accept_rd   = read & ~waitrequest;
    assign bc_eff      = eff_count(burstcount);
    assign beat_idx    = DEPTH_LOG2'(32'(base_q) + 32'(beat_q));

    // Next-state, memory strobes and sticky protocol-error detection
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        beat_d    = beat_q;
        drain_d   = drain_q;
        perr_d    = perr_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = beat_idx;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_wr) begin
                    ram_we    = 1'b1;
                    ram_waddr = address[DEPTH_LOG2-1:0];
                    base_d    = address[DEPTH_LOG2-1:0];
                    count_d   = bc_eff;
                    beat_d    = BCNT_W'(1);
                    if ((burstcount == '0) || read) perr_d = 1'b1;
                    if (bc_eff > BCNT_W'(1)) state_d = ST_WRITE_BURST;
                end else if (accept_rd) begin
                    base_d  = address[DEPTH_LOG2-1:0];
                    count_d = bc_eff;
                    beat_d  = '0;
                    if (burstcount == '0) perr_d = 1'b1;
                    state_d = ST_READ_ISSUE;
                end
            end
            ST_WRITE_BURST: begin
                if (read) perr_d = 1'b1;
                if (accept_wr) begin
                    ram_we = 1'b1;
                    beat_d = beat_q + BCNT_W'(1);
                    if (beat_q == count_q - BCNT_W'(1)) state_d = ST_IDLE;
                end
            end
            ST_READ_ISSUE: begin
                ram_re = 1'b1;
                beat_d = beat_q + BCNT_W'(1);
                if (beat_q == count_q - BCNT_W'(1)) begin
                    state_d = ST_READ_DRAIN;
                    drain_d = DRAIN_W'(READ_LATENCY - 2);
                end
            end
            ST_READ_DRAIN: begin
                if (drain_q == '0) state_d = ST_IDLE;
                else               drain_d = drain_q - DRAIN_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM and control registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            count_q <= BCNT_W'(1);
            beat_q  <= '0;
            drain_q <= '0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
        end
    end

    responder_ram #(
        .ADDR_BITS (DEPTH_LOG2)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (writedata),
        .wbe   (byteenable),
        .re    (ram_re),
        .raddr (beat_idx),
        .rdata (ram_rdata)
    );

    // Shift valid/data behind the RAM; data stages only load on valid so the
    // output word holds between beats
    always_comb begin
        ram_vld_d = ram_re;
        for (int i = 0; i < NSTG; i++) begin
            pipe_vld_d[i] = 1'b0;
            pipe_dat_d[i] = pipe_dat_q[i];
        end
        pipe_vld_d[0] = ram_vld_q;
        if (ram_vld_q) pipe_dat_d[0] = ram_rdata;
        for (int i = 1; i < NSTG; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            if (pipe_vld_q[i-1]) pipe_dat_d[i] = pipe_dat_q[i-1];
        end
    end

    // Latency pipeline registers, flushed by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_vld_q <= 1'b0;
            for (int i = 0; i < NSTG; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_dat_q[i] <= '0;
            end
        end else begin
            ram_vld_q <= ram_vld_d;
            for (int i = 0; i < NSTG; i++) begin
                pipe_vld_q[i] <= pipe_vld_d[i];
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
        end
    end

    assign readdatavalid  = pipe_vld_q[NSTG-1];
    assign readdata       = pipe_dat_q[NSTG-1];
    assign busy           = busy_q;
    assign protocol_error = perr_q;

endmodule

// File: doc/avalon_burst_responder.md
AVALON_BURST_RESPONDER -- requirements
Module: avalon_burst_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: log2 of the number of 64-bit words in backing memory.
REQ-002 Parameter READ_LATENCY, default 2: cycles from read acceptance to the first readdatavalid; legal range 2..8.
REQ-003 clock  input  1  sole clock; all logic is rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  29  64-bit word address of the burst start.
REQ-006 burstcount  input  8  beats in the burst, sampled at command acceptance only.
REQ-007 read  input  1  read command request.
REQ-008 write  input  1  write beat request.
REQ-009 writedata  input  64  write beat data.
REQ-010 byteenable  input  8  per-byte write enable, bit i gates writedata[8i+7:8i].
REQ-011 stall  input  1  test backpressure; forces waitrequest high.
REQ-012 waitrequest  output  1  slave not accepting the current read/write.
REQ-013 readdata  output  64  read beat data.
REQ-014 readdatavalid  output  1  readdata valid this cycle.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 protocol_error  output  1  sticky master-protocol violation flag.

Function
REQ-017 The block SHALL implement an Avalon-MM burst slave that responds to the front-buffer reader and the back-buffer writer masters.
REQ-018 The FSM SHALL have states IDLE, WRITE_BURST, READ_ISSUE and READ_DRAIN.
REQ-019 Accept rule: a read/write is accepted on a rising edge with the request high and waitrequest low.
REQ-020 waitrequest SHALL equal stall OR (state is READ_ISSUE or READ_DRAIN).
REQ-021 Memory index SHALL be (start address + beat number) modulo 2^DEPTH_LOG2; upper address bits are ignored and bursts wrap silently.
REQ-022 IDLE + accepted write: write beat 0, latch address and burstcount; go to WRITE_BURST if burstcount > 1, else stay in IDLE.
REQ-023 WRITE_BURST: each accepted write stores one beat; after the final beat, return to IDLE; cycles with write low do not advance the beat counter.
REQ-024 Byte lanes with byteenable=0 SHALL be left unchanged in memory.
REQ-025 IDLE + accepted read: latch address and burstcount, then go to READ_ISSUE on the next cycle.
REQ-026 READ_ISSUE: issue one memory read per cycle, regardless of stall, until all beats are issued, then go to READ_DRAIN.
REQ-027 Read acceptance at edge T: beat k SHALL present readdatavalid=1 on the cycle following edge T+READ_LATENCY+k, with beats back-to-back and no gaps.
REQ-028 READ_DRAIN SHALL return to IDLE on the cycle the final beat is valid, so waitrequest is low on the next cycle unless stall is high.
REQ-029 burstcount=0 at acceptance SHALL be treated as 1 and SHALL set protocol_error.
REQ-030 read and write both high while accepted in IDLE: write wins, the read is dropped, protocol_error is set.
REQ-031 read high during WRITE_BURST SHALL set protocol_error and be ignored.
REQ-032 A write followed immediately by a read of the same word SHALL return the new data (write-before-read ordering).
REQ-033 readdata SHALL hold its last value when readdatavalid is low.
REQ-034 Beat counters SHALL be 8 bits; a burstcount of 255 completes without overflow.

Reset
REQ-035 While reset is high: state=IDLE, waitrequest=1, readdatavalid=0, readdata=0, busy=0, protocol_error=0, and the latency pipeline is flushed.
REQ-036 Reset asserted mid-burst SHALL abandon the burst with no further readdatavalid pulses.
REQ-037 Memory contents SHALL NOT be cleared by reset.
REQ-038 After reset release, waitrequest SHALL be low on the first cycle unless stall is high.

Structure
REQ-039 Package rush3d_avalon_pkg SHALL hold the data, address and burstcount widths and the FSM state enumeration.
REQ-040 Sub-module responder_ram SHALL provide the simple dual-port synchronous RAM with byte-enable write, 1-cycle read latency and write-first behaviour.
REQ-041 The remaining READ_LATENCY-1 stages SHALL be a valid/data shift pipeline in the top level.

Verification
REQ-042 Write burst address=0x10, burstcount=4, data 0xA0..0xA3, byteenable=0xFF; then read same address, burstcount=4 -> readdatavalid on 4 consecutive cycles starting at T+3 with data 0xA0..0xA3.
REQ-043 Write 0xFFFF_FFFF_FFFF_FFFF to word 5, then write 0 with byteenable=0x0F -> a read of word 5 returns 0xFFFF_FFFF_0000_0000.
REQ-044 Write burst at address 0xFE, burstcount=4 -> data lands in words 0xFE, 0xFF, 0x00, 0x01; a read of 0x00 returns beat 2.
REQ-045 stall held high for 5 cycles while write is pending -> no acceptance and no memory change; first beat is accepted the cycle after stall falls.
REQ-046 read and write asserted together in IDLE -> write stored, no readdatavalid pulse, protocol_error=1 and remains 1 until reset.
REQ-047 Reset pulsed after beat 1 of an 8-beat read -> readdatavalid=0 from reset onward, and memory intact on the subsequent read-back.
